pipelined_mem_responder: RTL and testbench

Memory-side responder for the cache fill interface. The cache miss handler drives memory_enable and memory_address and expects memory_data and memory_data_valid back. This block accepts one request per cycle (read or write) on a single port and returns read data after a fixed LATENCY. Up to LATENCY reads may be in flight at once. It sits between the I- and D-cache miss handlers and the backing word array.

---
 rtl/pipelined_mem_responder.sv | 152 +++++++++++++++
 tb/tb_pipelined_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipelined_mem_responder.sv
// Word-array responder for the cache fill path: one read or write per cycle, read data back after LATENCY cycles.
// Reads return exactly LATENCY cycles after acceptance with up to LATENCY in flight; no backpressure, every strobe is taken.

module cla_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         term;
    logic         c_acc;

    // Each carry is formed directly from generate/propagate terms rather than rippled.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        term  = 1'b0;
        c_acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            c_acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c_acc = c_acc | term;
            end
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = c_acc | term;
        end
        sum  = p ^ c[W-1:0];
        cout = c[W];
    end

endmodule

module pipelined_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [3:0]            outstanding
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] addr_unused;

    logic [LATENCY-1:0]    pipe_vld_q;
    logic [LATENCY-1:0]    pipe_vld_d;
    logic [DATA_WIDTH-1:0] pipe_dat_q [LATENCY];
    logic [DATA_WIDTH-1:0] pipe_dat_d [LATENCY];
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] hold_d;
    logic [3:0]            outstanding_q;
    logic [3:0]            outstanding_d;
    logic [3:0]            out_delta;
    logic [3:0]            out_sum;
    logic                  out_cout_unused;

    // Byte address, halfword aligned: bit 0 and bits above the array size alias.
    assign word_idx    = addr[DEPTH_LOG2:1];
    assign addr_unused = addr;

    assign rd_acc = rst & enable & ~wr;
    assign wr_acc = rst & enable & wr;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_array[word_idx] <= data_in;
        end
    end

    assign data_valid  = pipe_vld_q[LATENCY-1];
    assign data_out    = data_valid ? pipe_dat_q[LATENCY-1] : hold_q;
    assign outstanding = outstanding_q;

    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = rd_acc;
        pipe_dat_d[0] = mem_array[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end
        hold_d = data_valid ? pipe_dat_q[LATENCY-1] : hold_q;
    end

    // A read entering while another returns leaves the count unchanged.
    always_comb begin
        out_delta = 4'b0000;
        if (rd_acc && !data_valid) begin
            out_delta = 4'b0001;
        end else if (!rd_acc && data_valid) begin
            out_delta = 4'b1111;
        end
        outstanding_d = out_sum;
    end

    cla_adder #(.W(4)) u_out_add (
        .a    (outstanding_q),
        .b    (out_delta),
        .cin  (1'b0),
        .sum  (out_sum),
        .cout (out_cout_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld_q    <= '0;
            hold_q        <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat_q[i] <= '0;
            end
        end else begin
            pipe_vld_q    <= pipe_vld_d;
            hold_q        <= hold_d;
            outstanding_q <= outstanding_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Directed bench: requests drive a scoreboard of {data, due cycle}; a negedge monitor pops and checks returns.
// Also tracks outstanding against the scoreboard depth and data_out hold behaviour between returns.

module tb_pipelined_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  outstanding;

    typedef struct {
        logic [15:0] dat;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [4096];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    logic [15:0] last_ret = 16'h0000;
    int          max_out  = 0;

    always #5 clk = ~clk;

    pipelined_mem_responder #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .DEPTH_LOG2(12),
        .LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr          (wr),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .outstanding (outstanding)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("outstanding", 32'(outstanding), 32'(sb.size()));
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
            if (data_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(data_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rdata", 32'(data_out), 32'(e.dat));
                    check("rlatency", 32'(cyc), 32'(e.due));
                    last_ret = e.dat;
                end
            end else begin
                check("hold", 32'(data_out), 32'(last_ret));
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("missing_valid", 32'(data_valid), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    function automatic int widx(input logic [15:0] a);
        return int'((a >> 1) & 16'h0FFF);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            rst = 1'b1; enable = 1'b0; wr = 1'b0;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk); #1;
        rst = 1'b1; enable = 1'b1; wr = 1'b1; addr = a; data_in = d;
        model[widx(a)] = d;
    endtask

    task automatic do_read(input logic [15:0] a);
        @(negedge clk); #1;
        rst = 1'b1; enable = 1'b1; wr = 1'b0; addr = a; data_in = 16'h0000;
        sb.push_back('{dat: model[widx(a)], due: cyc + LAT});
    endtask

    // Reset cycles also present a write strobe that must be ignored.
    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            rst = 1'b0; enable = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'hDEAD;
            sb.delete();
            last_ret = 16'h0000;
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

        do_reset(2);
        mon_en = 1'b1;
        idle(10);

        do_write(16'h0010, 16'hBEEF);
        do_read(16'h0010);
        idle(8);
        check("single_hold", 32'(data_out), 32'h0000BEEF);

        for (int i = 0; i < 8; i++) do_write(16'(16'h1000 + 2 * i), 16'(16'hA000 + i));
        max_out = 0;
        for (int i = 0; i < 8; i++) do_read(16'(16'h1000 + 2 * i));
        idle(8);
        check("peak_outstanding", 32'(max_out), 32'd4);
        check("burst_last", 32'(data_out), 32'h0000A007);

        do_write(16'h0003, 16'h1234);
        do_read(16'h2002);
        idle(6);
        check("alias_data", 32'(data_out), 32'h00001234);

        do_read(16'h0010);
        do_read(16'h0010);
        do_read(16'h0010);
        do_reset(2);
        idle(8);
        check("midflight_outstanding", 32'(outstanding), 32'd0);
        check("midflight_dout", 32'(data_out), 32'd0);
        do_read(16'h0010);
        idle(6);
        check("retained", 32'(data_out), 32'h0000BEEF);

        do_write(16'h0020, 16'h1111);
        do_read(16'h0020);
        do_write(16'h0020, 16'h5555);
        do_read(16'h0020);
        idle(8);
        check("rmw_final", 32'(data_out), 32'h00005555);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check("drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
